// File: rtl/acc_arb_pkg.sv
// acc_arb_pkg: shared state type and size limits for accumulator_arbiter
package acc_arb_pkg;
    typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t;
    localparam int MAX_INPUTS = 16;
endpackage

// File: rtl/round_robin_picker.sv
// round_robin_picker: first requester after last_grant_i, wrapping modulo N.
// With ACC_ARB_FIXED_PRIORITY_EN defined it becomes a lowest-index priority encoder.
module round_robin_picker
    import acc_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_grant_i,
    output logic         found_o,
    output logic [W-1:0] index_o
);
    logic [W-1:0] idx;
    always_comb begin
        found_o = |req_i;
        index_o = '0;
        idx     = '0;
`ifdef ACC_ARB_FIXED_PRIORITY_EN
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) index_o = W'(i);
`else
        // farthest offset first, so the nearest requester is the final assignment
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(last_grant_i) + k) % N);
            if (req_i[idx]) index_o = idx;
        end
`endif
    end
endmodule

// File: rtl/accumulator_arbiter.sv
// accumulator_arbiter: packet-locking arbiter feeding one registered output stage.
// Define ACC_ARB_FIXED_PRIORITY_EN for lowest-index priority instead of round-robin.
module accumulator_arbiter
    import acc_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [NUM_INPUTS-1:0]                 input_valid,
    output logic [NUM_INPUTS-1:0]                 input_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] input_data,
    input  logic [NUM_INPUTS-1:0]                 input_last,
    output logic                                  output_valid,
    input  logic                                  output_ready,
    output logic [DATA_WIDTH-1:0]                 output_data,
    output logic                                  output_last,
    output logic [ID_WIDTH-1:0]                   output_id
);
    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d, id_q, id_d, last_grant, pick;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, last_q, last_d, found, accept;

`ifdef ACC_ARB_FIXED_PRIORITY_EN
    assign last_grant = '0;
`else
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    assign last_grant   = last_grant_q;
    assign last_grant_d = (accept && input_last[grant_q]) ? grant_q : last_grant_q;
`endif

    round_robin_picker #(.N(NUM_INPUTS), .W(ID_WIDTH)) u_picker (
        .req_i        (input_valid),
        .last_grant_i (last_grant),
        .found_o      (found),
        .index_o      (pick)
    );

    // ready depends only on registered state and the downstream ready
    assign input_ready = (state_q == ARB_LOCKED && (!valid_q || output_ready))
                         ? NUM_INPUTS'(1) << grant_q : '0;
    assign accept      = input_valid[grant_q] && input_ready[grant_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q && !output_ready;
        data_d  = data_q;
        last_d  = last_q;
        id_d    = id_q;
        if (state_q == ARB_IDLE && found) begin
            state_d = ARB_LOCKED;
            grant_d = pick;
        end
        if (accept) begin
            valid_d = 1'b1;
            data_d  = input_data[grant_q];
            last_d  = input_last[grant_q];
            id_d    = grant_q;
            state_d = input_last[grant_q] ? ARB_IDLE : state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            last_q       <= 1'b0;
            id_q         <= '0;
`ifndef ACC_ARB_FIXED_PRIORITY_EN
            last_grant_q <= ID_WIDTH'(NUM_INPUTS - 1);
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            last_q       <= last_d;
            id_q         <= id_d;
`ifndef ACC_ARB_FIXED_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign output_valid = valid_q;
    assign output_data  = data_q;
    assign output_last  = last_q;
    assign output_id    = id_q;
endmodule

// File: tb/tb_accumulator_arbiter.sv
// tb_accumulator_arbiter: randomized and directed checks against a packet-level arbitration model
module tb_accumulator_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic                 clock = 1'b0, reset_n = 1'b0;
    logic [N-1:0]         input_valid, input_ready, input_last;
    logic [N-1:0][DW-1:0] input_data;
    logic                 output_valid, output_ready, output_last;
    logic [DW-1:0]        output_data;
    logic [IW-1:0]        output_id;

    int tests = 0, fails = 0, cyc = 0;
    logic [N-1:0]  hold;
    logic [8:0]    src_q [N][$];
    logic [10:0]   obs_q [$], exp_q [$];
    int            obs_cyc_q [$], exp_cyc_q [$];
    logic [N-1:0]  hist_rdy  [256];
    logic          hist_ov   [256];
    logic [DW-1:0] hist_data [256];

    accumulator_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .input_valid(input_valid), .input_ready(input_ready),
        .input_data(input_data), .input_last(input_last),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_data(output_data), .output_last(output_last), .output_id(output_id)
    );

    always #5 clock = ~clock;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            input_valid[i] = src_q[i].size() > 0 && !hold[i];
            input_data[i]  = input_valid[i] ? src_q[i][0][7:0] : '0;
            input_last[i]  = input_valid[i] ? src_q[i][0][8] : 1'b0;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] fire;
        @(negedge clock);
        fire = input_valid & input_ready;
        if (cyc < 256) begin
            hist_rdy[cyc]  = input_ready;
            hist_ov[cyc]   = output_valid;
            hist_data[cyc] = output_data;
        end
        if (output_valid && output_ready) begin
            obs_q.push_back({output_id, output_last, output_data});
            obs_cyc_q.push_back(cyc);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) if (fire[i]) void'(src_q[i].pop_front());
        cyc++;
        drive();
    endtask

    task automatic start();
        cyc = 0;
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete(); exp_cyc_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        hold = '0;
        output_ready = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        start();
    endtask

    task automatic push_pkt(input int src, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) src_q[src].push_back({k == len - 1, base + 8'(k)});
    endtask

    task automatic run(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) cycle();
    endtask

    // Packet-level model: whole packets granted in arbitration order; with an always-ready sink
    // the first beat lands 2 cycles after arbitration starts and each packet is followed by one idle cycle.
    task automatic build_expected(input int lg, input int t0);
        logic [8:0] m [N][$];
        logic [8:0] beat;
        int t, w, c;
        t = t0 + 2;
        for (int i = 0; i < N; i++) m[i] = src_q[i];
        w = 0;
        while (w >= 0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
`ifdef ACC_ARB_FIXED_PRIORITY_EN
                c = k - 1;
`else
                c = (lg + k) % N;
`endif
                if (w < 0 && m[c].size() > 0) w = c;
            end
            if (w >= 0) begin
                lg = w;
                do begin
                    beat = m[w].pop_front();
                    exp_q.push_back({IW'(w), beat});
                    exp_cyc_q.push_back(t);
                    t++;
                end while (!beat[8]);
                t++;
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({output_valid, output_last, output_id, output_data, input_ready} !== '0) begin
            fails++;
            $display("FAIL reset_state: got v=%b l=%b id=%0d d=%h rdy=%b, exp all zero",
                     output_valid, output_last, output_id, output_data, input_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        push_pkt(2, 3, 8'h01);
        build_expected(N - 1, 0);
        drive();
        run(3, 20);
        cycle();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL single_count: got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
                fails++;
                $display("FAIL single_beat%0d: got %h@%0d exp %h@%0d", i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
        tests++;
        if (hist_rdy[0] !== 4'b0000 || hist_rdy[1] !== 4'b0100) begin
            fails++; $display("FAIL single_ready: got c0=%b c1=%b exp 0000 0100", hist_rdy[0], hist_rdy[1]);
        end
        tests++;
        if (hist_ov[5] !== 1'b0) begin
            fails++; $display("FAIL single_idle: got valid=%b at cycle 5 exp 0", hist_ov[5]);
        end
    endtask

    task automatic test_two();
        do_reset();
        push_pkt(0, 2, 8'h10);
        push_pkt(1, 2, 8'h20);
        build_expected(N - 1, 0);
        drive();
        run(4, 30);
        repeat (3) cycle();
        start();
        push_pkt(1, 2, 8'h30);
        push_pkt(0, 2, 8'h40);
        build_expected(1, 0);
        drive();
        run(4, 30);
        tests++;
        if (obs_q.size() != 4) begin
            fails++; $display("FAIL two_count: got %0d exp 4", obs_q.size());
        end
        foreach (exp_q[i]) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
                fails++;
                $display("FAIL two_round2_beat%0d: got %h@%0d exp %h@%0d", i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_pkt(1, 4, 8'h50);
        build_expected(N - 1, 0);
        drive();
        repeat (3) cycle();
        output_ready = 1'b0;
        repeat (4) cycle();
        output_ready = 1'b1;
        run(4, 20);
        for (int c = 3; c <= 6; c++) begin
            tests++;
            if ({hist_ov[c], hist_rdy[c], hist_data[c]} !== {1'b1, 4'b0000, 8'h51}) begin
                fails++;
                $display("FAIL stall_c%0d: got v=%b rdy=%b d=%h exp v=1 rdy=0000 d=51", c, hist_ov[c], hist_rdy[c], hist_data[c]);
            end
        end
        tests++;
        if (obs_q.size() != 4) begin
            fails++; $display("FAIL stall_count: got %0d exp 4", obs_q.size());
        end
        foreach (exp_q[i]) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL stall_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rr_all();
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'h80 + 16 * r + i));
        build_expected(N - 1, 0);
        drive();
        run(12, 100);
        tests++;
        if (obs_q.size() != 12) begin
            fails++; $display("FAIL rr_count: got %0d exp 12", obs_q.size());
        end
        foreach (exp_q[i]) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
                fails++;
                $display("FAIL rr_beat%0d: got %h@%0d exp %h@%0d", i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_late();
        logic [5:0] rdy3;
        do_reset();
        push_pkt(1, 4, 8'h60);
        push_pkt(3, 1, 8'hAA);
        build_expected(N - 1, 0);
        hold = 4'b1000;
        drive();
        repeat (3) cycle();
        hold = '0;
        drive();
        run(5, 30);
        for (int c = 0; c < 6; c++) rdy3[c] = hist_rdy[c][3];
        tests++;
        if (rdy3 !== 6'b0 || hist_rdy[6] !== 4'b1000) begin
            fails++; $display("FAIL late_ready3: got c0..5=%b c6=%b exp 000000 1000", rdy3, hist_rdy[6]);
        end
        foreach (exp_q[i]) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
                fails++;
                $display("FAIL late_beat%0d: got %h@%0d exp %h@%0d", i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_pkt(1, 1, 8'h70);
        drive();
        run(1, 20);
        repeat (2) cycle();
        push_pkt(2, 4, 8'h90);
        drive();
        repeat (4) cycle();
        tests++;
        if (output_valid !== 1'b1) begin
            fails++; $display("FAIL rstmid_busy: got valid=%b exp 1", output_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({output_valid, output_last, output_id, output_data, input_ready} !== '0) begin
            fails++;
            $display("FAIL rstmid_async: got v=%b l=%b id=%0d d=%h rdy=%b exp all zero",
                     output_valid, output_last, output_id, output_data, input_ready);
        end
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        start();
        push_pkt(3, 1, 8'hA0);
        push_pkt(0, 1, 8'hB0);
        build_expected(N - 1, 0);
        drive();
        run(2, 20);
        foreach (exp_q[i]) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
                fails++;
                $display("FAIL rstmid_beat%0d: got %h@%0d exp %h@%0d", i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int p = 0; p < 10; p++)
                push_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), 8'($urandom));
            build_expected(N - 1, 0);
            drive();
            for (int i = 0; i < 800 && obs_q.size() < exp_q.size(); i++) begin
                output_ready = $urandom_range(0, 3) != 0;
                cycle();
            end
            tests++;
            if (obs_q.size() != exp_q.size()) begin
                fails++; $display("FAIL rand%0d_count: got %0d exp %0d", r, obs_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                tests++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    fails++; $display("FAIL rand%0d_beat%0d: got %h exp %h", r, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        hold = '0;
        output_ready = 1'b1;
        drive();
        #3;
        test_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        test_single();
        test_two();
        test_backpressure();
        test_rr_all();
        test_late();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/accumulator_arbiter.md
# accumulator_arbiter

Packet-locking arbiter that shares one accumulator datapath among NUM_INPUTS requesters. Each requester presents a valid/ready byte stream framed by a last flag. The arbiter grants one requester at a time, forwards its whole packet through a single registered output stage, and tags each beat with the source index. It sits directly upstream of the accumulator's valid/ready input.

## Interface
Parameters:
- NUM_INPUTS, 4, number of requesters (2..16)
- DATA_WIDTH, 8, beat width; matches accumulator input width
- ID_WIDTH, $clog2(NUM_INPUTS), width of output_id (derived, not overridden)

Ports:
- clock  in  1  single clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- input_valid  in  NUM_INPUTS  per-requester VALID
- input_ready  out  NUM_INPUTS  per-requester READY
- input_data  in  NUM_INPUTS x DATA_WIDTH  per-requester data
- input_last  in  NUM_INPUTS  final beat of a packet
- output_valid  out  1  output VALID
- output_ready  in  1  output READY (from accumulator)
- output_data  out  DATA_WIDTH  forwarded beat
- output_last  out  1  forwarded last flag
- output_id  out  ID_WIDTH  index of the granted source

## Operation
- States: ARB_IDLE, ARB_LOCKED.
- ARB_IDLE:
  - If any input_valid is high, pick a winner and register it as grant.
  - Go to ARB_LOCKED.
  - All input_ready are 0 in this state.
- Round-robin pick: search from last_grant+1, wrapping modulo NUM_INPUTS. The first index with valid high wins.
- ARB_LOCKED:
  - input_ready[grant] = !output_valid || output_ready.
  - All other input_ready are 0.
- Beat transfer: when input_valid[grant] && input_ready[grant]:
  - output_data, output_last and output_id load from the granted input.
  - output_valid is set to 1.
- Output handshake: output_valid && output_ready with no new beat accepted clears output_valid. If a beat is accepted in the same cycle, output_valid stays 1.
- Packet end: accepting a beat with input_last=1 does all of the following at that edge:
  - return to ARB_IDLE;
  - set last_grant to grant;
  - let the registered output drain independently.
- Requester rule: once asserted, input_valid stays high until the beat is accepted, and data stays stable meanwhile. The arbiter never revokes a grant mid-packet.
- Packets of any length are supported; a single-beat packet has last=1 on its first beat.
- Reset values:
  - output_valid=0, output_data=0, output_last=0, output_id=0;
  - state=ARB_IDLE;
  - last_grant=NUM_INPUTS-1, so input 0 has first priority.
- Reset mid-packet: the packet is dropped immediately, the output beat is discarded and there is no recovery handshake. Requesters are also reset.

## Timing
- Arbitration latency: valid high in ARB_IDLE at cycle 0, then:
  - grant registered at edge 1;
  - input_ready high during cycle 1;
  - first beat accepted at edge 2;
  - output_valid high in cycle 2.
- Throughput: one beat per cycle within a packet while output_ready=1.
- Inter-packet gap: exactly one ARB_IDLE cycle after each last beat.
- Backpressure: output_ready=0 with output_valid=1 forces input_ready[grant]=0. No beat is lost or duplicated.
- input_ready is combinational from output_valid, output_ready and state. There is no combinational path from any input_valid to any ready.

## Configuration
- ACC_ARB_FIXED_PRIORITY_EN:
  - Defined: the winner is the lowest valid index. last_grant is not implemented. Starvation is possible by design.
  - Undefined (default): round-robin as described above.

## Structure
- Package acc_arb_pkg holds:
  - typedef enum logic [0:0] arb_state_t {ARB_IDLE, ARB_LOCKED};
  - localparam MAX_INPUTS = 16.
- Sub-module round_robin_picker: combinational one-hot/index picker with inputs request vector and last_grant, and outputs found and index. Under the macro it degrades to a lowest-index priority encoder.

## Test plan
- Single requester, input 2, 3-beat packet 0x01,0x02,0x03 with output_ready=1 -> beats appear at cycles 2,3,4 with output_id=2; last on 0x03; idle at cycle 5.
- Inputs 0 and 1 both hold 2-beat packets from reset -> order is 0,0,1,1 with one gap cycle. A second round after input 0 re-requests grants 0 before 1 again.
- output_ready held 0 for 4 cycles mid-packet -> output_data stable, input_ready[grant]=0. Resuming gives no loss or duplication.
- All 4 inputs continuously requesting single-beat packets -> grant order is 0,1,2,3,0,... With ACC_ARB_FIXED_PRIORITY_EN it is always 0.
- A valid arriving on input 3 while input 1 is locked mid-packet -> input 3 stays not ready until after input 1's last beat.
- reset_n asserted mid-packet -> all outputs are zero asynchronously. After release, the next grant starts from input 0.
